// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
//   Bit-serial WIDTH-bit subtractor: computes (a - b) one bit per clock,
//   LSB first. Two half subtractors form the single-bit cell, and the
//   borrow is carried in a flop between bits. A start/done handshake
//   sequences the operation over WIDTH RUN cycles.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   request, sampled only while ready=1
//   a, b   in   minuend / subtrahend, captured on the accepting edge
//   ready  out  high in IDLE
//   busy   out  high in RUN
//   done   out  one-cycle pulse, diff/brw valid
//   diff   out  (a - b) mod 2^WIDTH, registered, held until next completion
//   brw    out  final borrow (a < b unsigned), registered
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             brw
);

  // Counter only has to reach WIDTH-1; keep at least one bit.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sb_reg, sd_reg, diff_reg;
  logic             bf_reg, brw_reg;
  logic [CW-1:0]    cnt_reg;

  logic x, y, d1, b1, d, b2, bout, last_bit;

  // Single-bit subtract cell: two cascaded half subtractors.
  always_comb begin
    x        = sa_reg[0];
    y        = sb_reg[0];
    d1       = x ^ y;
    b1       = ~x & y;
    d        = d1 ^ bf_reg;
    b2       = ~d1 & bf_reg;
    bout     = b1 | b2;
    last_bit = (cnt_reg == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg   <= '0;
      sb_reg   <= '0;
      sd_reg   <= '0;
      bf_reg   <= 1'b0;
      cnt_reg  <= '0;
      diff_reg <= '0;
      brw_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sa_reg  <= a;
            sb_reg  <= b;
            sd_reg  <= '0;
            bf_reg  <= 1'b0;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          sa_reg <= sa_reg >> 1;
          sb_reg <= sb_reg >> 1;
          // New difference bit enters at the MSB; after WIDTH shifts
          // bit 0 has landed in the LSB.
          sd_reg <= {d, sd_reg[WIDTH-1:1]};
          bf_reg <= bout;
          if (last_bit) begin
            // Results are published only here, so they stay frozen
            // through any later RUN until it completes.
            diff_reg <= {d, sd_reg[WIDTH-1:1]};
            brw_reg  <= bout;
          end else begin
            // Held at WIDTH-1 on the final bit so it never wraps.
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg == RUN);
  assign done  = (state_reg == DONE);
  assign diff  = diff_reg;
  assign brw   = brw_reg;

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial N-bit subtractor controller that computes `a - b` one bit per clock, LSB first. It uses a single-bit subtract cell built from two half subtractors, with the borrow carried in a flop between bits. Sequencing is driven by a start/done handshake with a bit counter. It sits next to the combinational subtractor cells and is the arithmetic-width extension for them, trading WIDTH cycles of latency for one bit of datapath.

## Interface
- `WIDTH` — default 8 — operand and result width in bits; legal range is 2..32.

- `clk` — in — 1 — rising-edge clock.
- `rst` — in — 1 — synchronous reset, active-high.
- `start` — in — 1 — request; sampled only while `ready`=1.
- `a` — in — WIDTH — minuend; captured on the accepting edge.
- `b` — in — WIDTH — subtrahend; captured on the accepting edge.
- `ready` — out — 1 — high in IDLE only.
- `busy` — out — 1 — high in RUN only.
- `done` — out — 1 — one-cycle pulse; result valid.
- `diff` — out — WIDTH — `(a - b) mod 2^WIDTH`; registered.
- `brw` — out — 1 — final borrow; 1 if and only if `a < b` (unsigned).

## Operation
- **State machine:** IDLE, RUN, DONE.
  - IDLE→RUN when `start`=1.
  - RUN→DONE when the bit counter reaches WIDTH-1.
  - DONE→IDLE unconditionally.
- **Accept (IDLE, `start`=1):**
  - Latch `a` into shift register SA and `b` into SB.
  - Clear the borrow flop `bf`, bit counter `cnt`, and partial-result shift register SD.
- **Per RUN cycle, bit i = `cnt`:**
  - Inputs are `x`=SA[0], `y`=SB[0] and `bf`.
  - Half subtractor 1: `d1 = x^y`, `b1 = ~x&y`.
  - Half subtractor 2: `d = d1^bf`, `b2 = ~d1&bf`.
  - Update `bf <= b1|b2`.
  - Shift SD right with `d` entering the MSB; shift SA and SB right by 1.
  - Increment `cnt`.
- **Final RUN cycle (`cnt`=WIDTH-1):**
  - Load `diff` with the fully shifted SD including this cycle's `d`.
  - Load `brw` with this cycle's `b1|b2`.
- **DONE:** assert `done` for exactly one cycle.
- **Result hold:** `diff` and `brw` hold until the next completion or reset. They do not change during a subsequent RUN.
- **`start` while not IDLE:** ignored, including during DONE. No queuing.
- **Operand changes:** changes on `a`/`b` after acceptance have no effect.
- **`cnt` width:** `$clog2(WIDTH)` bits, with a minimum of 1. It must never wrap mid-operation.
- **Reset (any state, including mid-RUN):**
  - State goes to IDLE.
  - `diff`, `brw`, `done`, `busy`, SA, SB, SD, `bf` and `cnt` are cleared to 0.
  - `ready` is 1.
  - An operation in progress is discarded with no `done` pulse.
- **Reset values:** `ready`=1, `busy`=0, `done`=0, `diff`=0, `brw`=0.

## Timing
- Accepting edge is E0, i.e. `start`=1 sampled with `ready`=1.
- Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
- At edge E_WIDTH: `diff`/`brw` are updated and the state enters DONE.
- `done`=1 in the cycle after E_WIDTH; `ready` returns to 1 after E_WIDTH+1.
- Throughput is one operation per WIDTH+2 cycles when `start` is held high.
- `busy`=1 for exactly WIDTH cycles per operation.
- All outputs are registered or decoded from state only. There is no combinational path from `start`, `a` or `b` to any output.
- `rst` has priority over `start` on the same edge.

## Test plan
- **Basic subtract:** WIDTH=8, `a`=8'h5A, `b`=8'h3C, `start` pulse. Required: `done` exactly 9 cycles after the accepting edge, `diff`=8'h1E, `brw`=0, `busy` high for 8 cycles.
- **Underflow:** `a`=8'h10, `b`=8'h20 → `diff`=8'hF0, `brw`=1. Then `a`=8'h00, `b`=8'h01 → `diff`=8'hFF, `brw`=1, proving the borrow ripples through all bits.
- **Edge operands:**
  - `a`=8'hFF, `b`=8'h00 → `diff`=8'hFF, `brw`=0.
  - `a`=`b`=8'hA5 → `diff`=8'h00, `brw`=0.
- **Handshake:**
  - Hold `start`=1 continuously with new operands each cycle. Only operands present on IDLE edges are used; results arrive every 10 cycles.
  - Results from the previous op stay stable during the next RUN.
  - `start` during DONE is ignored.
- **Reset mid-operation:**
  - Assert `rst` at bit 4 of `a`=8'h00, `b`=8'hFF. Next cycle: `ready`=1, `busy`=0, `diff`=0, `brw`=0, and no `done` pulse follows.
  - A fresh `start` with 8'h05 − 8'h03 then gives `diff`=8'h02.
- **Random sweep:** 1000 random operand pairs at WIDTH=8 and WIDTH=16, checked against the reference model `{brw, diff} = {1'b0, a} - {1'b0, b}`.
